// File: rtl/dram_ser_pkg.sv
// Shared types and constants for the DRAM write-data serialization controller.
package dram_ser_pkg;

    // Controller states: waiting for a request, waiting for a word, shifting a word out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Requester indices.
    localparam int REQ_HOST  = 0;
    localparam int REQ_TRAIN = 1;

    // Default geometry: byte-wide words, bursts of up to 16 words.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_BL_W  = 4;

endpackage

// File: rtl/dram_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// pointer; the pointer moves past the winner only when advance is high.
module dram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Pick the single requester, or the pointed-to one when both ask.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a grant the other requester gets priority.
    assign rr_ptr_d = gnt[0];

    // Pointer update; reset gives requester 0 priority.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rr_ptr_q <= 1'b0;
        end else if (advance && (|gnt)) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/dram_wr_ser_ctrl.sv
// Write-data serialization controller for one DQ lane. Arbitrates bursts
// between the host path (requester 0) and the training engine (requester 1),
// pulls words over valid/ready and loads an external LSB-first PISO, with a
// registered sideband (ser_valid/ser_first/ser_owner) aligned to its output.
// Optional build macro DRAM_WR_SER_STALL_CNT_EN adds a saturating stall_cnt
// output counting mid-burst underflow cycles.
module dram_wr_ser_ctrl
    import dram_ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BL_W  = DEF_BL_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [1:0]       req_valid,
    input  logic [BL_W-1:0]  req_len0,
    input  logic [BL_W-1:0]  req_len1,
    output logic [1:0]       req_gnt,
    input  logic [1:0]       wr_valid,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    output logic [1:0]       wr_ready,
    output logic             piso_load,
    output logic [WIDTH-1:0] piso_data,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_owner,
`ifdef DRAM_WR_SER_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t            state_q;
    logic              owner_q;
    logic [BL_W-1:0]   words_left_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              first_pend_q;
    logic [1:0]        req_gnt_q;
    logic              ser_valid_q;
    logic              ser_first_q;
    logic              busy_q;

    logic [1:0]        arb_gnt;
    logic              last_bit;
    logic              owner_valid;

    dram_rr_arb2 u_arb (
        .clk     (clk),
        .rst_b   (rst_b),
        .req     (req_valid),
        .advance (state_q == IDLE),
        .gnt     (arb_gnt)
    );

    assign last_bit    = (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign owner_valid = owner_q ? wr_valid[REQ_TRAIN] : wr_valid[REQ_HOST];

    // Ready goes only to the burst owner: while fetching, or on the last bit
    // of a word when more words remain so the next one loads without a gap.
    always_comb begin
        wr_ready = 2'b00;
        case (state_q)
            FETCH: wr_ready[owner_q] = 1'b1;
            SHIFT: if (last_bit && (words_left_q != '0)) wr_ready[owner_q] = 1'b1;
            default: wr_ready = 2'b00;
        endcase
    end

    assign piso_load = (|wr_ready) && owner_valid;
    assign piso_data = piso_load ? (owner_q ? wr_data1 : wr_data0) : '0;

    // Main FSM with registered grant and sideband outputs. words_left holds
    // len from grant; the first load keeps it, every later load decrements.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            first_pend_q <= 1'b0;
            req_gnt_q    <= 2'b00;
            ser_valid_q  <= 1'b0;
            ser_first_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            req_gnt_q   <= 2'b00;
            ser_first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|arb_gnt) begin
                        req_gnt_q    <= arb_gnt;
                        owner_q      <= arb_gnt[1];
                        words_left_q <= arb_gnt[1] ? req_len1 : req_len0;
                        first_pend_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (piso_load) begin
                        bit_cnt_q   <= '0;
                        ser_valid_q <= 1'b1;
                        state_q     <= SHIFT;
                        if (first_pend_q) begin
                            first_pend_q <= 1'b0;
                            ser_first_q  <= 1'b1;
                        end else begin
                            words_left_q <= words_left_q - BL_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end else if (words_left_q == '0) begin
                        ser_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (piso_load) begin
                        words_left_q <= words_left_q - BL_W'(1);
                        bit_cnt_q    <= '0;
                    end else begin
                        ser_valid_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    ser_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_gnt   = req_gnt_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_owner = owner_q;
    assign busy      = busy_q;

`ifdef DRAM_WR_SER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count FETCH cycles after the first word (underflow bubbles), saturating.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt_q <= 16'h0000;
        end else if ((state_q == FETCH) && !first_pend_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dram_wr_ser_ctrl.sv
`timescale 1ns/1ps
module tb_dram_wr_ser_ctrl;
    import dram_ser_pkg::*;

    localparam int WIDTH = 8;
    localparam int BL_W  = 4;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [1:0]       req_valid;
    logic [BL_W-1:0]  req_len0;
    logic [BL_W-1:0]  req_len1;
    logic [1:0]       req_gnt;
    logic [1:0]       wr_valid;
    logic [WIDTH-1:0] wr_data0;
    logic [WIDTH-1:0] wr_data1;
    logic [1:0]       wr_ready;
    logic             piso_load;
    logic [WIDTH-1:0] piso_data;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_owner;
    logic             busy;
`ifdef DRAM_WR_SER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    dram_wr_ser_ctrl #(.WIDTH(WIDTH), .BL_W(BL_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_len0  (req_len0),
        .req_len1  (req_len1),
        .req_gnt   (req_gnt),
        .wr_valid  (wr_valid),
        .wr_data0  (wr_data0),
        .wr_data1  (wr_data1),
        .wr_ready  (wr_ready),
        .piso_load (piso_load),
        .piso_data (piso_data),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_owner (ser_owner),
`ifdef DRAM_WR_SER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    // External LSB-first shift register fed by the controller.
    logic [WIDTH-1:0] sr_q;
    always @(posedge clk) begin
        if (piso_load) sr_q <= piso_data;
        else           sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Word sources (one per requester) with per-word hold-off counts.
    logic [WIDTH-1:0] src0[$];
    logic [WIDTH-1:0] src1[$];
    int               hold0[$];
    int               hold1[$];
    int               req_cnt[2];
    bit               noise1 = 1'b0;

    // Scoreboard: expected bit/owner stream and what the lane produced.
    logic exp_bits[$];
    logic exp_own[$];
    logic obs_bits[$];
    logic obs_own[$];
    logic [1:0] gnt_val_q[$];
    int         gnt_cyc_q[$];
    int sv_cnt, sv_first_cyc, sv_last_cyc, first_cnt, first_at_start, busy_last_cyc, rdy1_cnt;
    int exp_stall = 0;

    task automatic clear_obs();
        obs_bits.delete(); obs_own.delete();
        gnt_val_q.delete(); gnt_cyc_q.delete();
        sv_cnt = 0; sv_first_cyc = 0; sv_last_cyc = 0;
        first_cnt = 0; first_at_start = 0; busy_last_cyc = 0; rdy1_cnt = 0;
    endtask

    task automatic add_word(input int r, input logic [WIDTH-1:0] w, input int h);
        if (r == 0) begin src0.push_back(w); hold0.push_back(h); end
        else        begin src1.push_back(w); hold1.push_back(h); end
        for (int b = 0; b < WIDTH; b++) begin
            exp_bits.push_back(w[b]);
            exp_own.push_back(r[0]);
        end
    endtask

    // Present the front word of requester r; hold-off cycles are spent only
    // while the DUT is asking for a word.
    task automatic drive_src(input int r, input logic rdy);
        int n, h;
        logic [WIDTH-1:0] w;
        logic v;
        n = (r == 0) ? src0.size() : src1.size();
        v = 1'b0;
        w = '0;
        if (n > 0) begin
            w = (r == 0) ? src0[0] : src1[0];
            h = (r == 0) ? hold0[0] : hold1[0];
            if (h == 0) v = 1'b1;
            else if (rdy) begin
                if (r == 0) hold0[0] = h - 1; else hold1[0] = h - 1;
            end
            if (v && rdy) begin
                if (r == 0) begin void'(src0.pop_front()); void'(hold0.pop_front()); end
                else        begin void'(src1.pop_front()); void'(hold1.pop_front()); end
            end
        end else if (r == 1 && noise1) begin
            v = 1'($urandom_range(0, 1));
            w = WIDTH'($urandom);
        end
        wr_valid[r] = v;
        if (r == 0) wr_data0 = w; else wr_data1 = w;
    endtask

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic cycle();
        logic [1:0] rdy;
        @(negedge clk);
        cyc++;
        if (ser_valid) begin
            if (sv_cnt == 0) begin
                sv_first_cyc = cyc;
                if (ser_first) first_at_start = 1;
            end
            sv_last_cyc = cyc;
            sv_cnt++;
            obs_bits.push_back(sr_q[0]);
            obs_own.push_back(ser_owner);
        end
        if (ser_first) first_cnt++;
        if (busy) busy_last_cyc = cyc;
        if (noise1 && wr_ready[1]) rdy1_cnt++;
        if (req_gnt != 2'b00) begin
            gnt_val_q.push_back(req_gnt);
            gnt_cyc_q.push_back(cyc);
            if (req_gnt[0] && req_cnt[0] > 0) req_cnt[0]--;
            if (req_gnt[1] && req_cnt[1] > 0) req_cnt[1]--;
        end
        req_valid[0] = (req_cnt[0] > 0);
        req_valid[1] = (req_cnt[1] > 0);
        rdy = wr_ready;
        drive_src(0, rdy[0]);
        drive_src(1, rdy[1]);
    endtask

    task automatic run_done(input int max_cyc, output bit timed_out);
        int n;
        bit seen;
        n = 0; seen = 0; timed_out = 0;
        forever begin
            cycle();
            n++;
            if (busy) seen = 1;
            if (seen && !busy && req_cnt[0] == 0 && req_cnt[1] == 0 &&
                src0.size() == 0 && src1.size() == 0) break;
            if (n >= max_cyc) begin timed_out = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        req_valid = 2'b00; req_len0 = '0; req_len1 = '0;
        wr_valid = 2'b00; wr_data0 = '0; wr_data1 = '0;
        req_cnt[0] = 0; req_cnt[1] = 0;
        repeat (2) @(negedge clk);
        checks++; if (req_gnt !== 2'b00) begin errors++; $display("FAIL reset_req_gnt got %b want 00", req_gnt); end
        checks++; if (wr_ready !== 2'b00) begin errors++; $display("FAIL reset_wr_ready got %b want 00", wr_ready); end
        checks++; if (piso_load !== 1'b0 || piso_data !== '0) begin errors++; $display("FAIL reset_piso got %b/%h want 0/00", piso_load, piso_data); end
        checks++; if (ser_valid !== 1'b0 || ser_first !== 1'b0) begin errors++; $display("FAIL reset_ser got %b%b want 00", ser_valid, ser_first); end
        checks++; if (ser_owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b want 0", ser_owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef DRAM_WR_SER_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
        rst_b = 1'b1;
        clear_obs();
        repeat (2) cycle();
        checks++; if (busy_last_cyc != 0) begin errors++; $display("FAIL idle_busy got busy with no request want 0"); end
        $display("reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_both_req();
        bit to;
        logic [1:0] want[4];
        logic e, o, eo, oo;
        int n;
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        clear_obs();
        req_len0 = 4'd0; req_len1 = 4'd0;
        add_word(0, 8'h11, 0); add_word(1, 8'h22, 0);
        add_word(0, 8'h33, 0); add_word(1, 8'h44, 0);
        req_cnt[0] = 2; req_cnt[1] = 2; req_valid = 2'b11;
        run_done(200, to);
        checks++; if (to) begin errors++; $display("FAIL both_timeout got timeout want done"); end
        checks++; if (gnt_val_q.size() != 4) begin errors++; $display("FAIL both_gnt_count got %0d want 4", gnt_val_q.size()); end
        for (int k = 0; k < 4 && k < gnt_val_q.size(); k++) begin
            checks++;
            if (gnt_val_q[k] !== want[k]) begin errors++; $display("FAIL both_gnt[%0d] got %b want %b", k, gnt_val_q[k], want[k]); end
            if (k > 0) begin
                checks++;
                if (gnt_cyc_q[k] - gnt_cyc_q[k-1] != WIDTH + 2) begin
                    errors++; $display("FAIL both_gnt_gap[%0d] got %0d want %0d", k, gnt_cyc_q[k] - gnt_cyc_q[k-1], WIDTH + 2);
                end
            end
        end
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL both_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("both_req: grants=%0d bits=%0d errors=%0d", gnt_val_q.size(), sv_cnt, errors);
    endtask

    task automatic test_single();
        bit to;
        logic e, o, eo, oo;
        int n;
        clear_obs();
        req_len0 = 4'd1;
        add_word(0, 8'hA5, 0); add_word(0, 8'h3C, 0);
        req_cnt[0] = 1; req_valid = 2'b01;
        run_done(100, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout got timeout want done"); end
        checks++; if (gnt_val_q.size() != 1 || gnt_val_q[0] !== 2'b01) begin errors++; $display("FAIL single_gnt got %0d pulses want one 01", gnt_val_q.size()); end
        checks++; if (sv_cnt != 16) begin errors++; $display("FAIL single_valid_cnt got %0d want 16", sv_cnt); end
        checks++; if (sv_last_cyc - sv_first_cyc + 1 != 16) begin errors++; $display("FAIL single_gapless got span %0d want 16", sv_last_cyc - sv_first_cyc + 1); end
        if (gnt_cyc_q.size() > 0) begin
            checks++; if (sv_first_cyc != gnt_cyc_q[0] + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", sv_first_cyc - gnt_cyc_q[0], 1); end
        end
        checks++; if (first_cnt != 1 || first_at_start != 1) begin errors++; $display("FAIL single_first got cnt=%0d at_start=%0d want 1/1", first_cnt, first_at_start); end
        checks++; if (busy_last_cyc != sv_last_cyc) begin errors++; $display("FAIL single_busy_end got %0d want %0d", busy_last_cyc, sv_last_cyc); end
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL single_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("single: bits=%0d errors=%0d", sv_cnt, errors);
    endtask

    task automatic test_underflow();
        bit to;
        logic e, o, eo, oo;
        int n;
        clear_obs();
        req_len0 = 4'd2;
        add_word(0, 8'h5A, 0); add_word(0, 8'hC3, 4); add_word(0, 8'h0F, 0);
        exp_stall += 4;
        req_cnt[0] = 1; req_valid = 2'b01;
        run_done(100, to);
        checks++; if (to) begin errors++; $display("FAIL underflow_timeout got timeout want done"); end
        checks++; if (sv_cnt != 24) begin errors++; $display("FAIL underflow_valid_cnt got %0d want 24", sv_cnt); end
        checks++; if (sv_last_cyc - sv_first_cyc + 1 - sv_cnt != 4) begin errors++; $display("FAIL underflow_bubbles got %0d want 4", sv_last_cyc - sv_first_cyc + 1 - sv_cnt); end
`ifdef DRAM_WR_SER_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL underflow_stall got %0d want %0d", stall_cnt, exp_stall); end
`endif
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL underflow_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("underflow: bits=%0d bubbles=%0d errors=%0d", sv_cnt, sv_last_cyc - sv_first_cyc + 1 - sv_cnt, errors);
    endtask

    task automatic test_noise();
        bit to;
        logic e, o, eo, oo;
        int n;
        clear_obs();
        req_len0 = 4'd1;
        add_word(0, 8'h69, 0); add_word(0, 8'hF0, 0);
        noise1 = 1'b1;
        req_cnt[0] = 1; req_valid = 2'b01;
        run_done(100, to);
        noise1 = 1'b0;
        wr_valid[1] = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL noise_timeout got timeout want done"); end
        checks++; if (rdy1_cnt != 0) begin errors++; $display("FAIL noise_ready1 got %0d cycles want 0", rdy1_cnt); end
        checks++; if (sv_cnt != 16) begin errors++; $display("FAIL noise_valid_cnt got %0d want 16", sv_cnt); end
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL noise_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("noise: bits=%0d errors=%0d", sv_cnt, errors);
    endtask

    task automatic test_max();
        bit to;
        logic e, o, eo, oo;
        int n;
        clear_obs();
        req_len1 = 4'hF;
        for (int k = 0; k < 16; k++) add_word(1, WIDTH'($urandom), 0);
        req_cnt[1] = 1; req_valid = 2'b10;
        run_done(300, to);
        checks++; if (to) begin errors++; $display("FAIL max_timeout got timeout want done"); end
        checks++; if (gnt_val_q.size() != 1 || gnt_val_q[0] !== 2'b10) begin errors++; $display("FAIL max_gnt got %0d pulses want one 10", gnt_val_q.size()); end
        checks++; if (sv_cnt != 128) begin errors++; $display("FAIL max_valid_cnt got %0d want 128", sv_cnt); end
        checks++; if (sv_last_cyc - sv_first_cyc + 1 != 128) begin errors++; $display("FAIL max_gapless got span %0d want 128", sv_last_cyc - sv_first_cyc + 1); end
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL max_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("max: bits=%0d errors=%0d", sv_cnt, errors);
    endtask

    task automatic test_reset_mid();
        bit to;
        logic e, o, eo, oo;
        int n;
        clear_obs();
        req_len1 = 4'd3;
        for (int k = 0; k < 4; k++) add_word(1, 8'hC0 + 8'(k), 0);
        req_cnt[1] = 1; req_valid = 2'b10;
        n = 0;
        while (sv_cnt < WIDTH + 4 && n < 100) begin cycle(); n++; end
        checks++; if (sv_cnt != WIDTH + 4) begin errors++; $display("FAIL rstmid_reach got %0d bits want %0d", sv_cnt, WIDTH + 4); end
        // Assert reset between clock edges; outputs must clear without a clock.
        rst_b = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ser_valid !== 1'b0 || ser_owner !== 1'b0 || ser_first !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got busy=%b sv=%b own=%b first=%b want 0000", busy, ser_valid, ser_owner, ser_first);
        end
        checks++; if (wr_ready !== 2'b00 || piso_load !== 1'b0 || req_gnt !== 2'b00) begin
            errors++; $display("FAIL rstmid_comb got rdy=%b load=%b gnt=%b want 00/0/00", wr_ready, piso_load, req_gnt);
        end
`ifdef DRAM_WR_SER_STALL_CNT_EN
        exp_stall = 0;
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_stall got %0d want 0", stall_cnt); end
`endif
        req_cnt[1] = 0; req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) rst_b = 1'b1;
            checks++;
            if (wr_ready !== 2'b00 || piso_load !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rstmid_after[%0d] got rdy=%b load=%b busy=%b want 00/0/0", k, wr_ready, piso_load, busy);
            end
        end
        src0.delete(); hold0.delete(); src1.delete(); hold1.delete();
        exp_bits.delete(); exp_own.delete();
        wr_valid = 2'b00;
        clear_obs();
        req_len1 = 4'd0;
        add_word(1, 8'h96, 0);
        req_cnt[1] = 1; req_valid = 2'b10;
        run_done(100, to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_timeout got timeout want done"); end
        checks++; if (gnt_val_q.size() != 1 || gnt_val_q[0] !== 2'b10) begin errors++; $display("FAIL rstmid_gnt got %0d pulses want one 10", gnt_val_q.size()); end
        checks++; if (sv_cnt != WIDTH) begin errors++; $display("FAIL rstmid_valid_cnt got %0d want %0d", sv_cnt, WIDTH); end
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front(); eo = exp_own.pop_front(); o = 1'bx; oo = 1'bx;
            if (obs_bits.size() > 0) begin o = obs_bits.pop_front(); oo = obs_own.pop_front(); end
            checks++;
            if (o !== e || oo !== eo) begin errors++; $display("FAIL rstmid_bit[%0d] got %b/%b want %b/%b", i, o, oo, e, eo); end
        end
        $display("reset_mid: bits=%0d errors=%0d", sv_cnt, errors);
    endtask

    initial begin
        test_reset();
        test_both_req();
        test_single();
        test_underflow();
        test_noise();
        test_max();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
